// File: rtl/y86_pkg.sv
// Shared Y86-64 instruction-format definitions.
// Used by the instruction encoder and by the fetch stage that parses the same bytes.
package y86_pkg;

  localparam int MEM_DEPTH_DEFAULT = 1024;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [3:0] LEN_1  = 4'd1;
  localparam logic [3:0] LEN_2  = 4'd2;
  localparam logic [3:0] LEN_9  = 4'd9;
  localparam logic [3:0] LEN_10 = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } enc_state_t;

  // valc_offset of zero means the instruction carries no constant.
  typedef struct packed {
    logic       valid;
    logic [3:0] len;
    logic       has_regs;
    logic [3:0] valc_offset;
  } instr_fmt_t;

  function automatic logic [7:0] layout_byte(
    input instr_fmt_t  fmt,
    input logic [3:0]  icode,
    input logic [3:0]  ifun,
    input logic [3:0]  ra,
    input logic [3:0]  rb,
    input logic [63:0] valc,
    input logic [3:0]  k
  );
    logic [3:0] idx;
    logic [7:0] res;
    idx = k - fmt.valc_offset;
    if (k == 4'd0) begin
      res = {icode, ifun};
    end else if (fmt.has_regs && (k == 4'd1)) begin
      res = {ra, rb};
    end else if ((fmt.valc_offset != 4'd0) && (k >= fmt.valc_offset)) begin
      res = 8'(valc >> {idx, 3'b000});
    end else begin
      res = 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/y86_instr_format.sv
// Combinational icode -> instruction format lookup (validity, length, field placement).
module y86_instr_format
  import y86_pkg::*;
(
  input  logic [3:0] i_icode,
  output instr_fmt_t o_fmt
);

  // Format table; unknown icodes report valid=0.
  always_comb begin
    o_fmt = '0;
    case (i_icode)
      ICODE_HALT, ICODE_NOP, ICODE_RET: begin
        o_fmt = '{valid: 1'b1, len: LEN_1, has_regs: 1'b0, valc_offset: 4'd0};
      end
      ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ: begin
        o_fmt = '{valid: 1'b1, len: LEN_2, has_regs: 1'b1, valc_offset: 4'd0};
      end
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ: begin
        o_fmt = '{valid: 1'b1, len: LEN_10, has_regs: 1'b1, valc_offset: 4'd2};
      end
      ICODE_JXX, ICODE_CALL: begin
        o_fmt = '{valid: 1'b1, len: LEN_9, has_regs: 1'b0, valc_offset: 4'd1};
      end
      default: begin
        o_fmt = '0;
      end
    endcase
  end

endmodule

// File: rtl/y86_instr_encoder.sv
// Serialises one decoded Y86-64 instruction into byte-wide instruction memory,
// one byte per cycle, advancing an internal write pointer.
module y86_instr_encoder
  import y86_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  input  logic              pc_load,
  input  logic [63:0]       pc_load_val,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [63:0]       pc,
  output logic              done,
  output logic [63:0]       valP,
  output logic              mem_error,
  output logic              func_error
);

  localparam logic [64:0] DEPTH_W = 65'(MEM_DEPTH);

  enc_state_t        r_state;
  instr_fmt_t        r_fmt;
  logic [3:0]        r_k;
  logic [3:0]        r_icode;
  logic [3:0]        r_ifun;
  logic [3:0]        r_ra;
  logic [3:0]        r_rb;
  logic [63:0]       r_valc;
  logic [63:0]       r_pc;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_done;
  logic [63:0]       r_valp;
  logic              r_mem_error;
  logic              r_func_error;

  instr_fmt_t  w_in_fmt;
  logic        w_fits;
  logic        w_load_ok;
  logic        w_last;
  logic [3:0]  w_k_next;
  logic [7:0]  w_next_byte;
  logic [63:0] w_end_pc;

  y86_instr_format u_format (
    .i_icode (icode),
    .o_fmt   (w_in_fmt)
  );

  // 65-bit compares so a pointer near the top of the 64-bit range cannot wrap.
  assign w_fits      = ({1'b0, r_pc} + 65'(w_in_fmt.len)) <= DEPTH_W;
  assign w_load_ok   = {1'b0, pc_load_val} < DEPTH_W;
  assign w_k_next    = r_k + 4'd1;
  assign w_last      = (r_k == (r_fmt.len - 4'd1));
  assign w_end_pc    = r_pc + 64'(r_fmt.len);
  assign w_next_byte = layout_byte(r_fmt, r_icode, r_ifun, r_ra, r_rb, r_valc, w_k_next);

  assign in_ready   = (r_state == ST_IDLE) && !pc_load;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign pc         = r_pc;
  assign done       = r_done;
  assign valP       = r_valp;
  assign mem_error  = r_mem_error;
  assign func_error = r_func_error;

  // Encoder FSM: accept/validate in IDLE, one memory byte per cycle in EMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_fmt        <= '0;
      r_k          <= 4'd0;
      r_icode      <= 4'd0;
      r_ifun       <= 4'd0;
      r_ra         <= 4'd0;
      r_rb         <= 4'd0;
      r_valc       <= 64'd0;
      r_pc         <= 64'd0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 8'd0;
      r_done       <= 1'b0;
      r_valp       <= 64'd0;
      r_mem_error  <= 1'b0;
      r_func_error <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_mem_error  <= 1'b0;
      r_func_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_wr_en <= 1'b0;
          if (pc_load) begin
            if (w_load_ok) begin
              r_pc <= pc_load_val;
            end else begin
              r_mem_error <= 1'b1;
            end
          end else if (in_valid) begin
            r_fmt   <= w_in_fmt;
            r_icode <= icode;
            r_ifun  <= ifun;
            r_ra    <= rA;
            r_rb    <= rB;
            r_valc  <= valC;
            if (!w_in_fmt.valid) begin
              r_func_error <= 1'b1;
            end else if (!w_fits) begin
              r_mem_error <= 1'b1;
            end else begin
              // Byte 0 goes out on the cycle right after acceptance.
              r_state   <= ST_EMIT;
              r_k       <= 4'd0;
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_pc[ADDR_W-1:0];
              r_wr_data <= {icode, ifun};
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (w_last) begin
            r_wr_en <= 1'b0;
            r_pc    <= w_end_pc;
            r_valp  <= w_end_pc;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_k       <= w_k_next;
            r_wr_addr <= r_wr_addr + ADDR_W'(1);
            r_wr_data <= w_next_byte;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Self-checking bench for y86_instr_encoder: directed scenarios plus randomized
// instruction/pointer-load traffic against a byte-level reference model.
module tb_y86_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC;
  logic        pc_load;
  logic [63:0] pc_load_val;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [63:0] pc;
  logic        done;
  logic [63:0] valP;
  logic        mem_error;
  logic        func_error;

  int n_cmp = 0;
  int n_bad = 0;
  longint unsigned m_pc;

  always #5 clk = ~clk;

  y86_instr_encoder #(.MEM_DEPTH(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .pc_load(pc_load), .pc_load_val(pc_load_val),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pc(pc),
    .done(done), .valP(valP), .mem_error(mem_error), .func_error(func_error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction length by icode; 0 marks an illegal icode.
  function automatic int ref_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:        return 1;
      4'h2, 4'h6, 4'hA, 4'hB:  return 2;
      4'h3, 4'h4, 4'h5:        return 10;
      4'h7, 4'h8:              return 9;
      default:                 return 0;
    endcase
  endfunction

  // The 8-byte constant always occupies the last 8 bytes; a register byte exists
  // exactly when byte 1 is not part of the constant.
  function automatic logic [7:0] ref_byte(input logic [3:0] ic, input logic [3:0] fn,
                                          input logic [3:0] ra, input logic [3:0] rb,
                                          input logic [63:0] vc, input int k);
    int len;
    len = ref_len(ic);
    if (k == 0) return {ic, fn};
    if (len >= 9 && k >= len - 8) return 8'((vc >> (8 * (k - (len - 8)))) & 64'hFF);
    return {ra, rb};
  endfunction

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc, input bit poke_load);
    int len;
    len = ref_len(ic);
    @(negedge clk);
    icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
    in_valid = 1'b1; pc_load = 1'b0;
    #1 chk("rdy_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    if (len == 0) begin
      chk("func_err", func_error, 1);
      chk("func_memerr", mem_error, 0);
      chk("func_wren", wr_en, 0);
      chk("func_pc", pc, m_pc);
      chk("func_rdy", in_ready, 1);
    end else if (m_pc + longint'(len) > 1024) begin
      chk("fit_memerr", mem_error, 1);
      chk("fit_funcerr", func_error, 0);
      chk("fit_wren", wr_en, 0);
      chk("fit_pc", pc, m_pc);
      chk("fit_rdy", in_ready, 1);
    end else begin
      for (int k = 0; k < len; k++) begin
        chk("wr_en", wr_en, 1);
        chk("wr_addr", 64'(wr_addr), (m_pc + longint'(k)) % 1024);
        chk("wr_data", 64'(wr_data), 64'(ref_byte(ic, fn, ra, rb, vc, k)));
        chk("rdy_emit", in_ready, 0);
        chk("done_early", done, 0);
        if (poke_load && k == 0) begin
          pc_load = 1'b1;
          pc_load_val = 64'($urandom_range(0, 1023));
        end
        if (k == len - 1) pc_load = 1'b0;
        @(negedge clk);
      end
      m_pc += longint'(len);
      chk("done", done, 1);
      chk("valP", valP, m_pc);
      chk("pc_after", pc, m_pc);
      chk("wren_after", wr_en, 0);
      chk("rdy_after", in_ready, 1);
      chk("err_after", {mem_error, func_error}, 0);
    end
  endtask

  task automatic do_load(input logic [63:0] val, input bit with_valid);
    @(negedge clk);
    pc_load = 1'b1; pc_load_val = val; in_valid = with_valid;
    #1 chk("rdy_load", in_ready, 0);
    @(negedge clk);
    pc_load = 1'b0; in_valid = 1'b0;
    if (val < 64'd1024) begin
      m_pc = val;
      chk("load_err", mem_error, 0);
    end else begin
      chk("load_err", mem_error, 1);
    end
    chk("load_pc", pc, m_pc);
    chk("load_wren", wr_en, 0);
    chk("load_done", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; pc_load = 1'b0; pc_load_val = 64'd0;
    icode = 4'h0; ifun = 4'h0; rA = 4'h0; rB = 4'h0; valC = 64'd0;
    m_pc = 0;
    repeat (2) @(negedge clk);
    chk("rst_wren", wr_en, 0);
    chk("rst_addr", 64'(wr_addr), 0);
    chk("rst_data", 64'(wr_data), 0);
    chk("rst_pc", pc, 0);
    chk("rst_flags", {done, mem_error, func_error}, 0);
    chk("rst_valp", valP, 0);
    rst_n = 1'b1;
    #1 chk("rst_rdy", in_ready, 1);

    send(4'h3, 4'h0, 4'hF, 4'h3, 64'hA, 1'b0);
    send(4'h8, 4'h0, 4'h0, 4'h0, 64'd100, 1'b0);
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0);
    chk("pc_20", pc, 20);
    send(4'hC, 4'h0, 4'h1, 4'h2, 64'd5, 1'b0);

    icode = 4'h1;
    do_load(64'd40, 1'b1);
    send(4'h7, 4'h3, 4'h0, 4'h0, 64'h0123_4567_89AB_CDEF, 1'b1);

    do_load(64'd1020, 1'b0);
    send(4'h3, 4'h0, 4'hF, 4'h1, 64'd7, 1'b0);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0);
    do_load(64'd1024, 1'b0);
    chk("pc_1021", pc, 1021);

    // Reset on the 4th byte of rmmovq abandons it immediately.
    do_load(64'd0, 1'b0);
    @(negedge clk);
    icode = 4'h4; ifun = 4'h0; rA = 4'h2; rB = 4'h7; valC = 64'h1122_3344_5566_7788;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmm_b3_addr", 64'(wr_addr), 3);
    chk("rmm_b3_data", 64'(wr_data), 64'(ref_byte(4'h4, 4'h0, 4'h2, 4'h7, 64'h1122_3344_5566_7788, 3)));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {wr_en, done, mem_error, func_error}, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_addr", 64'(wr_addr), 0);
    chk("mid_rst_data", 64'(wr_data), 0);
    m_pc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send(4'h6, 4'h3, 4'h5, 4'h9, 64'd0, 1'b0);

    for (int i = 0; i < 250; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 15) begin
        int s;
        s = $urandom_range(0, 3);
        if (s == 0)      do_load(64'($urandom_range(0, 1023)), 1'b0);
        else if (s == 1) do_load(64'($urandom_range(1000, 1023)), 1'b0);
        else if (s == 2) do_load(64'($urandom_range(1024, 1100)), 1'b1);
        else             do_load({32'($urandom), 32'($urandom)} | 64'h8000_0000_0000_0000, 1'b0);
      end else begin
        send(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
             {32'($urandom), 32'($urandom)}, ($urandom_range(0, 9) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/y86_instr_encoder.md
Name: y86_instr_encoder

Overview:
- Write-side counterpart of the SEQ fetch stage.
- Accepts one decoded Y86-64 instruction (icode, ifun, rA, rB, valC) and serialises it into the byte-wide instruction memory, one byte per cycle, in the exact byte layout that fetch parses.
- Keeps its own write pointer, so a testbench or boot loader can stream a whole program into instruction memory at consecutive addresses.

Parameters:
- MEM_DEPTH, 1024, number of bytes in instruction memory.
- ADDR_W, 10, width of wr_addr; must equal clog2(MEM_DEPTH).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction fields are valid.
- in_ready  out  1  encoder can accept; combinational, = (state==IDLE) && !pc_load.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- rA  in  4  register A specifier.
- rB  in  4  register B specifier.
- valC  in  64  constant, emitted little-endian.
- pc_load  in  1  load the write pointer.
- pc_load_val  in  64  new write pointer value.
- wr_en  out  1  memory write strobe, registered.
- wr_addr  out  ADDR_W  memory byte address, registered.
- wr_data  out  8  memory byte, registered.
- pc  out  64  current write pointer, i.e. the next free byte.
- done  out  1  one-cycle pulse after the last byte of an instruction.
- valP  out  64  address following the completed instruction; valid while done=1.
- mem_error  out  1  one-cycle pulse: instruction would not fit, or pc_load_val out of range.
- func_error  out  1  one-cycle pulse: icode > 4'hB.

Behaviour:
- Reset (async, rst_n=0) clears every register:
  - state=IDLE, pc=0, wr_en=0, wr_addr=0, wr_data=0, done=0, valP=0, mem_error=0, func_error=0.
  - Reset mid-EMIT abandons the instruction. Bytes already written stay in memory; pc does not advance.
- Instruction lengths (len):
  - 1 byte: halt (0), nop (1), ret (9).
  - 2 bytes: rrmovq/cmovXX (2), OPq (6), pushq (A), popq (B).
  - 10 bytes: irmovq (3), rmmovq (4), mrmovq (5).
  - 9 bytes: jXX (7), call (8).
- Byte layout:
  - byte0 = {icode, ifun}.
  - For icodes 2,3,4,5,6,A,B: byte1 = {rA, rB}.
  - icodes 3,4,5: valC[7:0]..valC[63:56] in bytes 2..9.
  - icodes 7,8: valC in bytes 1..8.
  - Unused fields are ignored.
- FSM states: IDLE, EMIT.
- IDLE:
  - pc_load=1 takes priority over in_valid. If pc_load_val < MEM_DEPTH, pc <= pc_load_val; otherwise mem_error pulses and pc is unchanged.
  - Accept occurs when in_valid && in_ready at cycle N; all fields are latched.
  - icode > B: func_error pulses at N+1, no writes, stay IDLE.
  - pc + len > MEM_DEPTH (64-bit compare, no wrap): mem_error pulses at N+1, no writes, stay IDLE.
  - Otherwise go to EMIT with byte index k=0.
- EMIT:
  - Byte k is presented on cycle N+1+k with wr_en=1, wr_addr=pc[ADDR_W-1:0]+k, and wr_data set to the layout byte.
  - in_ready=0 throughout; pc_load is ignored.
  - After byte len-1: pc <= pc+len, done=1 and valP=pc+len on cycle N+1+len, return to IDLE.
  - in_ready is 1 again on cycle N+1+len.
- Throughput: len+1 cycles per instruction.
- wr_en is 0 whenever not in EMIT.
- done, mem_error and func_error are mutually exclusive, and each pulses for exactly one cycle.

Decomposition:
- Shared package y86_pkg:
  - icode localparams: ICODE_HALT..ICODE_POPQ, 4'h0..4'hB.
  - Length constants LEN_1, LEN_2, LEN_9, LEN_10.
  - MEM_DEPTH default.
  - The fetch stage must use the same package.
- One sub-module, y86_instr_format:
  - Combinational; maps icode to {valid, len[3:0], has_regs, valc_offset[3:0]}.
  - Shared with future fetch/decode checkers.

Test Plan:
1. irmovq (icode 3, ifun 0, rA=F, rB=3, valC=0xA) at pc=0 -> bytes 30 F3 0A 00 00 00 00 00 00 00 at addresses 0..9 on consecutive cycles; then done=1, valP=10, pc=10.
2. call (icode 8, valC=100) at pc=10 -> bytes 80 64 00 00 00 00 00 00 00 at addresses 10..18; then valP=19. Follow with halt -> byte 00 at address 19, pc=20.
3. icode=4'hC at any pc -> func_error one cycle, wr_en never asserted, pc unchanged, in_ready back to 1 next cycle.
4. pc_load_val=1020 then irmovq -> mem_error, no writes, pc=1020. Then nop -> byte 10 at address 1020, pc=1021. Then pc_load_val=1024 -> mem_error, pc stays 1021.
5. pc_load and in_valid asserted together in IDLE -> load wins, instruction not accepted (in_ready=0). During EMIT, pc_load is ignored.
6. rst_n=0 at the 4th byte of rmmovq -> all outputs 0 immediately, pc=0. A subsequent OPq xorq (63, rA=5, rB=9) writes bytes 63 59 at addresses 0..1.
